// File: rtl/alu_stage_pkg.sv
// Shared constants and the queued beat layout for the ALU result stage.
package alu_stage_pkg;

  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;
  localparam int REG_BITS = 5;
  localparam int XZR_IDX  = 31;
  localparam int DEPTH    = 2;

  typedef struct packed {
    logic [63:0]         result;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
  } stage_entry_t;

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Two-entry in-order queue of stage_entry_t; push-to-output latency 1 cycle when empty.
// Ready depends only on registered occupancy, so a pop never admits a same-edge push when full.
module stage_fifo2
  import alu_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  stage_entry_t wr_entry,
  output logic         rd_valid,
  input  logic         rd_ready,
  output stage_entry_t rd_entry
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  stage_entry_t mem [DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  // Ready is held low while reset is asserted so nothing is taken in that cycle.
  assign wr_ready = reset && (count != FULL);
  assign rd_valid = (count != 2'd0);
  assign rd_entry = mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Buffers ALU result beats toward writeback and holds the architectural NZCV register.
// Flags update at the accepting edge; in_ready drops only on a full queue, never from out_ready.
module alu_result_stage
  import alu_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_result,
  input  logic        in_negative,
  input  logic        in_zero,
  input  logic        in_overflow,
  input  logic        in_carry_out,
  input  logic        in_set_flags,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic [3:0]  flags
);

  stage_entry_t in_entry;
  stage_entry_t head;
  logic         accept;
  logic [3:0]   flags_q;

  // Writes targeting the zero register are dropped here so writeback never sees them.
  always_comb begin
    in_entry           = '0;
    in_entry.result    = in_result;
    in_entry.rd        = in_rd;
    in_entry.reg_write = in_reg_write && (in_rd != 5'(XZR_IDX));
  end

  assign accept = in_valid && in_ready;

  stage_fifo2 u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_entry (in_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_entry (head)
  );

  assign out_result    = head.result;
  assign out_rd        = head.rd;
  assign out_reg_write = head.reg_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (accept && in_set_flags) begin
      flags_q[FLAG_N] <= in_negative;
      flags_q[FLAG_Z] <= in_zero;
      flags_q[FLAG_C] <= in_carry_out;
      flags_q[FLAG_V] <= in_overflow;
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted beats are queued, delivered beats compared in order.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic        in_negative, in_zero, in_overflow, in_carry_out;
  logic        in_set_flags;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [3:0]  flags;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        reg_write;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         pushed = 0;
  int         delivered = 0;
  logic [3:0] model_flags = 4'b0000;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_negative  (in_negative),
    .in_zero      (in_zero),
    .in_overflow  (in_overflow),
    .in_carry_out (in_carry_out),
    .in_set_flags (in_set_flags),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .flags        (flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: what is seen here is what the next rising edge acts on.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      model_flags = 4'b0000;
    end else begin
      check("flags_track", {60'd0, flags}, {60'd0, model_flags});
      check("out_valid_track", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_result", out_result, e.result);
          check("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
          check("sb_reg_write", {63'd0, out_reg_write}, {63'd0, e.reg_write});
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        e.result    = in_result;
        e.rd        = in_rd;
        e.reg_write = in_reg_write && (in_rd != 5'd31);
        sb.push_back(e);
        pushed++;
        if (in_set_flags)
          model_flags = {in_negative, in_zero, in_carry_out, in_overflow};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [4:0] rd,
                       input logic rw, input logic sf, input logic [3:0] nzcv);
    in_valid     = v;
    in_result    = r;
    in_rd        = rd;
    in_reg_write = rw;
    in_set_flags = sf;
    in_negative  = nzcv[3];
    in_zero      = nzcv[2];
    in_carry_out = nzcv[1];
    in_overflow  = nzcv[0];
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    check("drain_done", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 64'hDEAD, 5'd7, 1'b1, 1'b1, 4'b1111);

    // 1: reset with in_valid asserted
    step();
    step();
    sample();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_flags", {60'd0, flags}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    check("rst_out_reg_write", {63'd0, out_reg_write}, 64'd0);
    step();
    reset = 1'b1;
    drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 4'b0000);
    sample();
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    sample();
    check("post_rst_no_beat", {63'd0, out_valid}, 64'd0);

    // 2: single set-flags beat
    step();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b1, 1'b1, 4'b1000);
    step();
    drive(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 4'b0000);
    sample();
    check("t2_out_valid", {63'd0, out_valid}, 64'd1);
    check("t2_out_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_out_rd", {59'd0, out_rd}, 64'd3);
    check("t2_flags", {60'd0, flags}, 64'h8);
    drain();

    // 3: fill, backpressure, ordered drain, held beat C admitted late
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 5'd1, 1'b1, 1'b0, 4'b0000);
    step();
    drive(1'b1, 64'hB, 5'd2, 1'b1, 1'b0, 4'b0000);
    step();
    drive(1'b1, 64'hC, 5'd4, 1'b1, 1'b0, 4'b0000);
    sample();
    check("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
    check("t3_head_a_rd", {59'd0, out_rd}, 64'd1);
    step();
    sample();
    check("t3_hold_rd", {59'd0, out_rd}, 64'd1);
    check("t3_hold_result", out_result, 64'hA);
    check("t3_c_blocked", {63'd0, in_ready}, 64'd0);
    step();
    out_ready = 1'b1;
    sample();
    check("t3_no_bypass", {63'd0, in_ready}, 64'd0);
    step();
    sample();
    check("t3_head_b_rd", {59'd0, out_rd}, 64'd2);
    check("t3_ready_after_pop", {63'd0, in_ready}, 64'd1);
    n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    check("t3_c_wait", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    sample();
    check("t3_head_c_rd", {59'd0, out_rd}, 64'd4);
    check("t3_head_c_result", out_result, 64'hC);
    drain();

    // 4: zero-register write suppressed
    out_ready = 1'b0;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 5'd31, 1'b1, 1'b0, 4'b0000);
    step();
    in_valid = 1'b0;
    sample();
    check("t4_reg_write", {63'd0, out_reg_write}, 64'd0);
    check("t4_result", out_result, 64'h1234_5678_9ABC_DEF0);
    check("t4_rd", {59'd0, out_rd}, 64'd31);
    drain();

    // 5: flags ignore non-setting beats, then SUBS 5-5
    drive(1'b1, 64'd7, 5'd5, 1'b1, 1'b0, 4'b0110);
    step();
    in_valid = 1'b0;
    sample();
    check("t5_flags_kept", {60'd0, flags}, 64'h8);
    step();
    drive(1'b1, 64'd0, 5'd6, 1'b1, 1'b1, 4'b0110);
    step();
    in_valid = 1'b0;
    sample();
    check("t5_flags_subs", {60'd0, flags}, 64'h6);
    drain();

    // 6: steady push+pop at occupancy 1
    out_ready = 1'b0;
    drive(1'b1, 64'h100, 5'd8, 1'b1, 1'b0, 4'b0000);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h101 + 64'(i), 5'(9 + i), 1'b1, 1'b0, 4'b0000);
      step();
      sample();
      check("t6_out_valid", {63'd0, out_valid}, 64'd1);
      check("t6_in_ready", {63'd0, in_ready}, 64'd1);
      check("t6_result", out_result, 64'h101 + 64'(i));
    end
    drain();

    step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("beat_count", 64'(delivered), 64'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
